// File: rtl/mac_frame_collector.sv
// rtl/mac_frame_collector.sv - sums fixed-length frames of MAC results into a buffered, saturating total
package p;
   localparam int SIZE_DATA_OUT = 16;
endpackage

module mac_frame_collector #(
   parameter int SIZE_DATA_OUT = p::SIZE_DATA_OUT,
   parameter int SIZE_SUM      = SIZE_DATA_OUT + 2,
   parameter int FRAME_LEN     = 8,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [SIZE_DATA_OUT-1:0]        data_in,
   input  logic                            in_valid,
   input  logic                            flush,
   output logic [SIZE_SUM-1:0]             out_data,
   output logic                            out_sat,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            drop_flag
);

   localparam int CW = $clog2(FRAME_LEN);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int SW = SIZE_SUM + 1;
   localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

   // frame accumulation state
   logic [SIZE_SUM-1:0] acc_q, acc_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                fsat_q, fsat_d;

   // output buffer state
   logic [SIZE_SUM-1:0] mem_data_q [FIFO_DEPTH];
   logic                mem_sat_q  [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]       level_q, level_d;
   logic                drop_q;

   logic [SW-1:0]       sum_wide;
   logic [SIZE_SUM-1:0] frame_total;
   logic                frame_sat;
   logic                close_frame;
   logic                pop;
   logic                push;

   // fold the current sample into the running total and decide whether the frame closes
   always_comb begin
      sum_wide    = {1'b0, acc_q} + SW'(data_in);
      frame_total = acc_q;
      frame_sat   = fsat_q;
      if (in_valid) begin
         if (sum_wide[SIZE_SUM]) begin
            frame_total = '1;
            frame_sat   = 1'b1;
         end else begin
            frame_total = sum_wide[SIZE_SUM-1:0];
         end
      end
      // a flush only closes a frame that actually holds at least one sample
      close_frame = (in_valid && (cnt_q == LAST)) ||
                    (flush && ((cnt_q != '0) || in_valid));
      acc_d  = frame_total;
      fsat_d = frame_sat;
      cnt_d  = in_valid ? cnt_q + CW'(1) : cnt_q;
      if (close_frame) begin
         acc_d  = '0;
         cnt_d  = '0;
         fsat_d = 1'b0;
      end
   end

   // a full buffer still accepts a push when the head leaves on the same edge
   always_comb begin
      pop     = (level_q != '0) && out_ready;
      push    = close_frame && ((level_q < LW'(FIFO_DEPTH)) || pop);
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // frame accumulator registers
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         fsat_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         fsat_q <= fsat_d;
      end
   end

   // output buffer, pointers, level and sticky drop indication
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         drop_q   <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_data_q[i] <= '0;
            mem_sat_q[i]  <= 1'b0;
         end
      end else begin
         if (push) begin
            mem_data_q[wr_ptr_q] <= frame_total;
            mem_sat_q[wr_ptr_q]  <= frame_sat;
            wr_ptr_q             <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         level_q <= level_d;
         if (close_frame && !push) begin
            drop_q <= 1'b1;
         end
      end
   end

   assign out_data   = mem_data_q[rd_ptr_q];
   assign out_sat    = mem_sat_q[rd_ptr_q];
   assign out_valid  = (level_q != '0);
   assign fifo_level = level_q;
   assign drop_flag  = drop_q;

endmodule

// File: tb/tb_mac_frame_collector.sv
// tb/tb_mac_frame_collector.sv - self-checking bench for mac_frame_collector
module tb_mac_frame_collector;

   localparam int DW    = 16;
   localparam int SUMW  = 18;
   localparam int FLEN  = 8;
   localparam int DEPTH = 4;
   localparam longint MAXS = (64'd1 << SUMW) - 1;

   logic            clk;
   logic            reset;
   logic [DW-1:0]   data_in;
   logic            in_valid;
   logic            flush;
   logic [SUMW-1:0] out_data;
   logic            out_sat;
   logic            out_valid;
   logic            out_ready;
   logic [2:0]      fifo_level;
   logic            drop_flag;

   int total_cnt;
   int bad_cnt;

   mac_frame_collector #(
      .SIZE_DATA_OUT(DW),
      .SIZE_SUM(SUMW),
      .FRAME_LEN(FLEN),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .data_in(data_in),
      .in_valid(in_valid),
      .flush(flush),
      .out_data(out_data),
      .out_sat(out_sat),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .fifo_level(fifo_level),
      .drop_flag(drop_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: running frame sum, sample count, and a queue of finished frames
   longint unsigned m_acc;
   int              m_cnt;
   bit              m_fsat;
   bit              m_drop;
   longint unsigned m_qd[$];
   bit              m_qs[$];

   function automatic void model_update();
      bit     pop_now;
      bit     close_now;
      longint s;
      if (reset) begin
         m_acc = 0; m_cnt = 0; m_fsat = 0; m_drop = 0;
         m_qd.delete(); m_qs.delete();
         return;
      end
      pop_now = (m_qd.size() > 0) && out_ready;
      if (in_valid) begin
         s = longint'(m_acc) + longint'(data_in);
         if (s > MAXS) begin
            s = MAXS;
            m_fsat = 1;
         end
         m_acc = longint'(s);
         m_cnt++;
      end
      close_now = (m_cnt == FLEN) || (flush && m_cnt > 0);
      if (pop_now) begin
         void'(m_qd.pop_front());
         void'(m_qs.pop_front());
      end
      if (close_now) begin
         if (m_qd.size() < DEPTH) begin
            m_qd.push_back(m_acc);
            m_qs.push_back(m_fsat);
         end else begin
            m_drop = 1;
         end
         m_acc = 0; m_cnt = 0; m_fsat = 0;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      total_cnt++;
      if (act != exp) begin
         bad_cnt++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".valid"}, longint'(out_valid), longint'(m_qd.size() > 0));
      chk({tag, ".level"}, longint'(fifo_level), longint'(m_qd.size()));
      chk({tag, ".drop"},  longint'(drop_flag), longint'(m_drop));
      if (m_qd.size() > 0) begin
         chk({tag, ".data"}, longint'(out_data), longint'(m_qd[0]));
         chk({tag, ".sat"},  longint'(out_sat),  longint'(m_qs[0]));
      end
   endtask

   task automatic idle();
      in_valid = 0; flush = 0; data_in = '0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      tick();
      reset = 0;
   endtask

   task automatic feed(input int n, input int val, input bit rdy);
      for (int k = 0; k < n; k++) begin
         in_valid = 1; flush = 0; data_in = DW'(val); out_ready = rdy;
         tick();
      end
      idle();
   endtask

   typedef struct {
      bit          v;
      logic [15:0] d;
      bit          f;
      bit          r;
      bit          ev;
      int          el;
      int          ed;
      bit          es;
   } vec_t;

   vec_t vq[$];

   task automatic add_vec(input bit v, input int d, input bit f, input bit r,
                          input bit ev, input int el, input int ed, input bit es);
      vec_t x;
      x.v = v; x.d = 16'(d); x.f = f; x.r = r;
      x.ev = ev; x.el = el; x.ed = ed; x.es = es;
      vq.push_back(x);
   endtask

   int drain_exp[4];

   initial begin
      total_cnt = 0;
      bad_cnt   = 0;
      out_ready = 0;
      idle();
      reset = 1;
      tick();
      tick();
      reset = 0;

      // reset state
      chk("rst.valid", longint'(out_valid), 0);
      chk("rst.level", longint'(fifo_level), 0);
      chk("rst.drop",  longint'(drop_flag), 0);
      chk("rst.data",  longint'(out_data), 0);
      chk("rst.sat",   longint'(out_sat), 0);

      // basic frame 1..8, then flush cases
      for (int i = 0; i < 7; i++) add_vec(1, i + 1, 0, 1, 0, 0, 0, 0);
      add_vec(1, 8, 0, 1, 1, 1, 36, 0);
      add_vec(0, 0, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) add_vec(1, 10, 0, 1, 0, 0, 0, 0);
      add_vec(0, 0, 1, 1, 1, 1, 30, 0);
      add_vec(0, 0, 1, 1, 0, 0, 0, 0);
      add_vec(1, 5, 0, 1, 0, 0, 0, 0);
      add_vec(1, 5, 1, 1, 1, 1, 10, 0);
      add_vec(0, 0, 0, 1, 0, 0, 0, 0);
      foreach (vq[i]) begin
         in_valid = vq[i].v; data_in = vq[i].d; flush = vq[i].f; out_ready = vq[i].r;
         tick();
         chk($sformatf("vec%0d.valid", i), longint'(out_valid), longint'(vq[i].ev));
         chk($sformatf("vec%0d.level", i), longint'(fifo_level), longint'(vq[i].el));
         if (vq[i].ev) begin
            chk($sformatf("vec%0d.data", i), longint'(out_data), longint'(vq[i].ed));
            chk($sformatf("vec%0d.sat", i),  longint'(out_sat),  longint'(vq[i].es));
         end
      end
      idle();

      // saturation, then a normal frame
      do_reset();
      feed(8, 16'hFFFF, 0);
      chk("sat.data", longint'(out_data), 262143);
      chk("sat.sat",  longint'(out_sat), 1);
      out_ready = 1; tick(); out_ready = 0;
      chk("sat.level0", longint'(fifo_level), 0);
      feed(8, 1, 0);
      chk("sat2.data", longint'(out_data), 8);
      chk("sat2.sat",  longint'(out_sat), 0);

      // backpressure and drop
      do_reset();
      feed(32, 2, 0);
      chk("bp.level4", longint'(fifo_level), 4);
      chk("bp.drop0",  longint'(drop_flag), 0);
      feed(8, 2, 0);
      chk("bp.level4b", longint'(fifo_level), 4);
      chk("bp.drop1",   longint'(drop_flag), 1);
      out_ready = 1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("bp.head%0d", k), longint'(out_data), 16);
         tick();
         chk($sformatf("bp.lvl%0d", k), longint'(fifo_level), 3 - k);
      end
      chk("bp.valid", longint'(out_valid), 0);
      chk("bp.dropst", longint'(drop_flag), 1);
      out_ready = 0;

      // full buffer with simultaneous pop and push
      do_reset();
      feed(32, 1, 0);
      feed(7, 3, 0);
      in_valid = 1; data_in = 16'd3; out_ready = 1;
      tick();
      idle();
      chk("fp.level", longint'(fifo_level), 4);
      chk("fp.drop",  longint'(drop_flag), 0);
      drain_exp = '{8, 8, 8, 24};
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("fp.order%0d", k), longint'(out_data), longint'(drain_exp[k]));
         tick();
      end
      chk("fp.empty", longint'(out_valid), 0);
      out_ready = 0;

      // reset mid-operation
      do_reset();
      feed(16, 1, 0);
      feed(5, 7, 0);
      chk("mr.level2", longint'(fifo_level), 2);
      do_reset();
      chk("mr.level", longint'(fifo_level), 0);
      chk("mr.valid", longint'(out_valid), 0);
      feed(8, 1, 0);
      chk("mr.data", longint'(out_data), 8);

      // randomized traffic against the reference model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         reset     = ($urandom_range(0, 599) == 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 9) == 0);
         out_ready = ($urandom_range(0, 9) < 4);
         data_in   = ($urandom_range(0, 2) == 0) ? DW'(16'hFFFF - $urandom_range(0, 15))
                                                 : DW'($urandom);
         tick();
         chk_model($sformatf("rnd%0d", c));
      end
      reset = 0;
      idle();

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
